// File: rtl/serialdump_if.sv
// Bus bundle for serialdump: control registers, CPU side, memory side and UART transmitter.
interface serialdump_if;
    // Control register port
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic        ready;

    // CPU-facing memory port
    logic [31:0] a_cpu;
    logic [31:0] d_cpu;
    logic        we_cpu;
    logic        rd_cpu;
    logic        burst_en_cpu;
    logic [7:0]  burst_length_cpu;
    logic [31:0] spo_cpu;
    logic        ready_cpu;

    // Memory-facing port
    logic [31:0] a_mem;
    logic [31:0] d_mem;
    logic        we_mem;
    logic        rd_mem;
    logic        burst_en_mem;
    logic [7:0]  burst_length_mem;
    logic [31:0] spo_mem;
    logic        ready_mem;

    // UART transmitter
    logic [7:0]  uart_tx_data;
    logic        uart_tx_we;
    logic        uart_tx_ready;

    // The dumper's view of the bundle
    modport slave (
        input  a, d, we,
        input  a_cpu, d_cpu, we_cpu, rd_cpu, burst_en_cpu, burst_length_cpu,
        input  spo_mem, ready_mem, uart_tx_ready,
        output ready, spo_cpu, ready_cpu,
        output a_mem, d_mem, we_mem, rd_mem, burst_en_mem, burst_length_mem,
        output uart_tx_data, uart_tx_we
    );

    // The surrounding system's view of the bundle
    modport master (
        output a, d, we,
        output a_cpu, d_cpu, we_cpu, rd_cpu, burst_en_cpu, burst_length_cpu,
        output spo_mem, ready_mem, uart_tx_ready,
        input  ready, spo_cpu, ready_cpu,
        input  a_mem, d_mem, we_mem, rd_mem, burst_en_mem, burst_length_mem,
        input  uart_tx_data, uart_tx_we
    );
endinterface

// File: rtl/serialdump.sv
// serialdump: reads N words from memory and sends each as 8 lowercase hex chars
// (MSB nibble first) over the UART, ending every dump with a single space.
// While dumping it owns the memory port and the CPU is stalled.
// Optional feature macro: SERIALDUMP_NEWLINE_EN inserts 0x0a after every
// WORDS_PER_LINE-th word (except the last).
module serialdump #(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned WORDS_PER_LINE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    serialdump_if.slave bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NIB_W  = 3;
    localparam int unsigned CHAR_W = 8;

    localparam logic [2:0] REG_ADDR  = 3'b001;
    localparam logic [2:0] REG_COUNT = 3'b010;
    localparam logic [2:0] REG_GO    = 3'b011;

    localparam logic [CHAR_W-1:0] CHAR_SPACE = 8'h20;
    localparam logic [CHAR_W-1:0] CHAR_NL    = 8'h0a;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_HEX,
        S_TXW,
        S_NEXT,
        S_TERM,
        S_TERMW,
        S_NL,
        S_NLW
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] word;
    logic [NIB_W-1:0]  nib;

    logic              busy;
    logic [DATA_W-1:0] d_swap;
    logic              reg_wr;
    logic              go;
    logic              line_end;
    logic [3:0]        nib_val;
    logic              tx_send_c;
    logic [CHAR_W-1:0] tx_char_c;

    // Register writes arrive byte-swapped; only accepted while idle
    assign d_swap  = {bus.d[7:0], bus.d[15:8], bus.d[23:16], bus.d[31:24]};
    assign busy    = (state != S_IDLE);
    assign reg_wr  = bus.we & ~busy;
    assign go      = reg_wr & (bus.a == REG_GO);
    assign nib_val = word[{nib, 2'b00} +: 4];

    assign bus.ready     = ~busy & ~bus.we;
    assign bus.spo_cpu   = bus.spo_mem;
    assign bus.ready_cpu = bus.ready_mem & ~busy;

`ifdef SERIALDUMP_NEWLINE_EN
    localparam int unsigned LINE_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    logic [LINE_W-1:0] line_cnt;

    assign line_end = (line_cnt == LINE_W'(WORDS_PER_LINE - 1));

    // Words emitted on the current line; cleared at each go and after a newline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_cnt <= '0;
        end else if (go) begin
            line_cnt <= '0;
        end else if (state == S_NEXT) begin
            line_cnt <= line_end ? '0 : line_cnt + LINE_W'(1);
        end
    end
`else
    logic unused_wpl;

    assign line_end   = 1'b0;
    assign unused_wpl = (WORDS_PER_LINE != 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = (count == '0) ? S_TERM : S_RD;
                end
            end
            S_RD: begin
                if (bus.ready_mem) begin
                    state_nxt = S_HEX;
                end
            end
            S_HEX: begin
                if (bus.uart_tx_ready) begin
                    state_nxt = S_TXW;
                end
            end
            S_TXW: begin
                state_nxt = (nib != '0) ? S_HEX : S_NEXT;
            end
            S_NEXT: begin
                if (count == CNT_W'(1)) begin
                    state_nxt = S_TERM;
                end else if (line_end) begin
                    state_nxt = S_NL;
                end else begin
                    state_nxt = S_RD;
                end
            end
            S_TERM: begin
                if (bus.uart_tx_ready) begin
                    state_nxt = S_TERMW;
                end
            end
            S_TERMW: begin
                state_nxt = S_IDLE;
            end
            S_NL: begin
                if (bus.uart_tx_ready) begin
                    state_nxt = S_NLW;
                end
            end
            S_NLW: begin
                state_nxt = S_RD;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs: char selection for the transmitter and the memory port override
    always_comb begin
        tx_send_c            = 1'b0;
        tx_char_c            = '0;
        bus.a_mem            = bus.a_cpu;
        bus.d_mem            = bus.d_cpu;
        bus.we_mem           = bus.we_cpu;
        bus.rd_mem           = bus.rd_cpu;
        bus.burst_en_mem     = bus.burst_en_cpu;
        bus.burst_length_mem = bus.burst_length_cpu;

        case (state)
            S_HEX: begin
                tx_send_c = bus.uart_tx_ready;
                tx_char_c = (nib_val < 4'd10) ? (8'h30 + CHAR_W'(nib_val))
                                              : (8'h57 + CHAR_W'(nib_val));
            end
            S_TERM: begin
                tx_send_c = bus.uart_tx_ready;
                tx_char_c = CHAR_SPACE;
            end
            S_NL: begin
                tx_send_c = bus.uart_tx_ready;
                tx_char_c = CHAR_NL;
            end
            default: begin
                tx_send_c = 1'b0;
            end
        endcase

        if (busy) begin
            bus.a_mem            = addr;
            bus.d_mem            = '0;
            bus.we_mem           = 1'b0;
            bus.rd_mem           = (state == S_RD);
            bus.burst_en_mem     = 1'b1;
            bus.burst_length_mem = 8'd1;
        end
    end

    // Datapath: control registers, fetched word, nibble pointer and UART strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr             <= '0;
            count            <= '0;
            word             <= '0;
            nib              <= '0;
            bus.uart_tx_we   <= 1'b0;
            bus.uart_tx_data <= '0;
        end else begin
            bus.uart_tx_we <= tx_send_c;
            if (tx_send_c) begin
                bus.uart_tx_data <= tx_char_c;
            end

            case (state)
                S_IDLE: begin
                    if (reg_wr && (bus.a == REG_ADDR)) begin
                        addr <= d_swap;
                    end
                    if (reg_wr && (bus.a == REG_COUNT)) begin
                        count <= d_swap[CNT_W-1:0];
                    end
                end
                S_RD: begin
                    if (bus.ready_mem) begin
                        word <= bus.spo_mem;
                        nib  <= NIB_W'(7);
                    end
                end
                S_TXW: begin
                    if (nib != '0) begin
                        nib <= nib - NIB_W'(1);
                    end
                end
                S_NEXT: begin
                    addr  <= addr + ADDR_W'(4);
                    count <= count - CNT_W'(1);
                end
                default: begin
                    addr <= addr;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serialdump.sv
// Testbench for serialdump: memory and UART models, a char/address scoreboard
// built from the dump rules, and directed tests with literal expectations.
module tb_serialdump;
    localparam int unsigned WPL = 2;

    logic clk = 1'b0;
    logic rst_n;

    serialdump_if bus();

    serialdump #(.CNT_W(24), .WORDS_PER_LINE(WPL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory contents: one fixed word, everything else derived from the address
    function automatic logic [31:0] mem_val(input logic [31:0] ad);
        if (ad == 32'h0000_0100) return 32'h12ab34cd;
        return {ad[15:0] ^ 16'hbeef, ad[15:0]};
    endfunction

    function automatic logic [31:0] swap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h61 + 8'(n) - 8'd10;
    endfunction

    // Memory model: answers rd_mem after mem_lat cycles (0 = same cycle)
    int mem_lat  = 1;
    int mem_wait = 0;
    always @(posedge clk) begin
        if (bus.rd_mem && !bus.ready_mem) mem_wait <= mem_wait + 1;
        else mem_wait <= 0;
    end
    always_comb begin
        bus.ready_mem = bus.rd_mem && (mem_wait >= mem_lat);
        bus.spo_mem   = mem_val(bus.a_mem);
    end

    // UART model: goes busy for 3 cycles after each strobe; hold_low forces it busy
    int   tx_cnt  = 0;
    logic hold_low = 1'b0;
    always @(posedge clk) begin
        if (bus.uart_tx_we) tx_cnt <= 3;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign bus.uart_tx_ready = (tx_cnt == 0) && !hold_low;

    // Capture of transmitted chars and dumper-issued reads
    logic [7:0]  got[$];
    logic [31:0] rd_seen[$];
    int          rd_cnt = 0;
    logic        prev_tx_ready = 1'b0;
    logic        prev_we = 1'b0;
    always @(posedge clk) begin
        prev_tx_ready <= bus.uart_tx_ready;
        prev_we       <= bus.uart_tx_we;
        if (bus.uart_tx_we) got.push_back(bus.uart_tx_data);
        if (bus.rd_mem && bus.ready_mem && !bus.ready && !bus.we) begin
            rd_seen.push_back(bus.a_mem);
            rd_cnt = rd_cnt + 1;
        end
    end

    // Scoreboard expectations
    logic [7:0]  exp_chr[$];
    logic [31:0] exp_adr[$];

    // Per-cycle compare against the scoreboard
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.uart_tx_we) begin
                checks++;
                if (exp_chr.size() == 0) begin
                    errors++;
                    $display("FAIL uart_char: got %02h, expected none", bus.uart_tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_chr.pop_front();
                    if (bus.uart_tx_data !== e) begin
                        errors++;
                        $display("FAIL uart_char: got %02h, expected %02h", bus.uart_tx_data, e);
                    end
                end
                checks++;
                if (!prev_tx_ready || prev_we) begin
                    errors++;
                    $display("FAIL strobe_handshake: tx_ready_at_edge=%0b prev_we=%0b, expected 1/0",
                             prev_tx_ready, prev_we);
                end
            end
            if (!bus.ready && !bus.we) begin
                checks++;
                if (bus.ready_cpu || bus.we_mem || (bus.d_mem != 32'h0) ||
                    (bus.burst_length_mem != 8'd1) || !bus.burst_en_mem) begin
                    errors++;
                    $display("FAIL busy_override: ready_cpu=%0b we_mem=%0b d_mem=%h bl=%0d be=%0b",
                             bus.ready_cpu, bus.we_mem, bus.d_mem, bus.burst_length_mem, bus.burst_en_mem);
                end
                if (bus.rd_mem && bus.ready_mem) begin
                    checks++;
                    if (exp_adr.size() == 0) begin
                        errors++;
                        $display("FAIL read_addr: got %h, expected no read", bus.a_mem);
                    end else begin
                        logic [31:0] ea;
                        ea = exp_adr.pop_front();
                        if (bus.a_mem !== ea) begin
                            errors++;
                            $display("FAIL read_addr: got %h, expected %h", bus.a_mem, ea);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic check_str(input string tag, input string lit);
        bit    ok;
        string a_s;
        string e_s;
        ok  = (got.size() == lit.len());
        a_s = "";
        e_s = "";
        foreach (got[i]) a_s = {a_s, $sformatf("%02h", got[i])};
        for (int i = 0; i < lit.len(); i++) begin
            e_s = {e_s, $sformatf("%02h", lit.getc(i))};
            if (i < got.size() && got[i] != lit.getc(i)) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got chars %s, expected %s", tag, a_s, e_s);
        end
    endtask

    task automatic check_sb_empty(input string tag);
        checks++;
        if (exp_chr.size() != 0 || exp_adr.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d chars and %0d reads still pending, expected 0",
                     tag, exp_chr.size(), exp_adr.size());
        end
    endtask

    task automatic wr(input logic [2:0] ra, input logic [31:0] rv);
        @(negedge clk);
        bus.a  = ra;
        bus.d  = rv;
        bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    // Fill the scoreboard from the dump rules, then program and start the dumper
    task automatic start_dump(input logic [31:0] ad, input int n);
        got.delete();
        rd_seen.delete();
        rd_cnt = 0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            logic [31:0] wa;
            wa = ad + 32'(4 * i);
            w  = mem_val(wa);
            exp_adr.push_back(wa);
            for (int k = 7; k >= 0; k--) exp_chr.push_back(hexc(w[4*k +: 4]));
`ifdef SERIALDUMP_NEWLINE_EN
            if (((i + 1) % WPL == 0) && (i != n - 1)) exp_chr.push_back(8'h0a);
`endif
        end
        exp_chr.push_back(8'h20);
        wr(3'b001, swap(ad));
        wr(3'b010, swap(32'(n)));
        wr(3'b011, 32'h0);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!bus.ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(bus.ready), 32'h1);
    endtask

    task automatic wait_chars(input string tag, input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(got.size() >= n), 32'h1);
    endtask

    task automatic cpu_read_done(input string tag, input logic [31:0] exp);
        int k;
        k = 0;
        while (!bus.ready_cpu && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, 32'(bus.ready_cpu), 32'h1);
        chk({tag, "_data"}, bus.spo_cpu, exp);
        @(negedge clk);
        bus.rd_cpu = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        bit  bad;
        bus.a                = 3'b000;
        bus.d                = 32'h0;
        bus.we               = 1'b0;
        bus.a_cpu            = 32'h0000_1234;
        bus.d_cpu            = 32'h0000_0055;
        bus.we_cpu           = 1'b0;
        bus.rd_cpu           = 1'b0;
        bus.burst_en_cpu     = 1'b0;
        bus.burst_length_cpu = 8'd4;
        rst_n                = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state: idle, no strobe, memory port follows the CPU
        chk("rst_ready", 32'(bus.ready), 32'h1);
        chk("rst_tx_we", 32'(bus.uart_tx_we), 32'h0);
        chk("rst_tx_data", 32'(bus.uart_tx_data), 32'h0);
        chk("rst_a_mem", bus.a_mem, 32'h0000_1234);
        chk("rst_d_mem", bus.d_mem, 32'h0000_0055);
        chk("rst_rd_mem", 32'(bus.rd_mem), 32'h0);
        chk("rst_burst_len", 32'(bus.burst_length_mem), 32'd4);
        chk("rst_burst_en", 32'(bus.burst_en_mem), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // One word; a CPU read posted mid-dump must wait for the dump to end
        mem_lat = 1;
        start_dump(32'h0000_0100, 1);
        bus.a_cpu  = 32'h0;
        bus.rd_cpu = 1'b1;
        wait_idle("one_word_idle");
        check_str("one_word_chars", "12ab34cd ");
        chk("one_word_strobes", 32'(got.size()), 32'd9);
        chk("one_word_reads", 32'(rd_cnt), 32'd1);
        check_sb_empty("one_word_sb");
        cpu_read_done("stalled_cpu_read", 32'hbeef_0000);

        // Empty dump: only the terminator, no memory reads
        start_dump(32'h0000_0100, 0);
        wait_idle("empty_idle");
        check_str("empty_chars", " ");
        chk("empty_reads", 32'(rd_cnt), 32'd0);
        check_sb_empty("empty_sb");

        // Address wraps from the top of memory to zero; same-cycle memory response
        mem_lat = 0;
        start_dump(32'hFFFF_FFFC, 2);
        wait_idle("wrap_idle");
        chk("wrap_nreads", 32'(rd_seen.size()), 32'd2);
        if (rd_seen.size() >= 2) begin
            chk("wrap_addr0", rd_seen[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", rd_seen[1], 32'h0000_0000);
        end
        check_str("wrap_chars", "4113fffcbeef0000 ");
        check_sb_empty("wrap_sb");

        // Transmitter held busy mid-word: nothing sent, nothing lost
        mem_lat = 2;
        start_dump(32'h0000_0100, 1);
        wait_chars("hold_reach3", 3);
        hold_low = 1'b1;
        n0 = got.size();
        repeat (50) @(negedge clk);
        chk("hold_no_strobe", 32'(got.size()), 32'(n0));
        hold_low = 1'b0;
        wait_idle("hold_idle");
        check_str("hold_chars", "12ab34cd ");
        check_sb_empty("hold_sb");

        // Three words: newline after the second word only when the feature is built in
        mem_lat = 1;
        start_dump(32'h0000_0200, 3);
        wait_idle("three_idle");
`ifdef SERIALDUMP_NEWLINE_EN
        check_str("three_chars", "bcef0200bceb0204\nbce70208 ");
`else
        check_str("three_chars", "bcef0200bceb0204bce70208 ");
`endif
        check_sb_empty("three_sb");

        // Reset mid-dump: abort, release the memory port, no further chars
        start_dump(32'h0000_0200, 2);
        wait_chars("abort_reach3", 3);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_chr.delete();
        exp_adr.delete();
        chk("abort_chars", 32'(got.size()), 32'd3);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.uart_tx_we || !bus.ready) bad = 1'b1;
            @(negedge clk);
        end
        chk("abort_quiet", 32'(bad), 32'h0);
        chk("abort_no_more", 32'(got.size()), 32'd3);
        bus.a_cpu  = 32'h0;
        bus.rd_cpu = 1'b1;
        @(negedge clk);
        chk("abort_a_mem", bus.a_mem, 32'h0);
        cpu_read_done("abort_cpu_read", 32'hbeef_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
